// File: rtl/mod_in_pwm_meas_if.sv
// Signal bundle between the mod_in pad / CPU status side and the PWM measurement block.
// Handshake: update_pulse_o is a one-cycle strobe with no back-pressure. In the cycle it is 1,
// period_count_o, duty_count_o, meas_valid_o, freq_err_o and static_level_o already carry the
// freshly written values, and they hold until the next strobe or until the block is cleared.
// mod_in_i and enable_i are plain level inputs.
interface mod_in_pwm_meas_if #(
   parameter int CNT_W = 21
);
   logic             mod_in_i;
   logic             enable_i;
   logic [CNT_W-1:0] period_count_o;
   logic [CNT_W-1:0] duty_count_o;
   logic             meas_valid_o;
   logic             update_pulse_o;
   logic             static_level_o;
   logic             freq_err_o;
   logic [1:0]       fsm_state_o;

   modport master (
      output mod_in_i, enable_i,
      input  period_count_o, duty_count_o, meas_valid_o, update_pulse_o,
             static_level_o, freq_err_o, fsm_state_o
   );

   modport slave (
      input  mod_in_i, enable_i,
      output period_count_o, duty_count_o, meas_valid_o, update_pulse_o,
             static_level_o, freq_err_o, fsm_state_o
   );
endinterface

// File: rtl/mod_in_pwm_meas.sv
// Period / high-time measurement of the asynchronous mod_in pin.
// Front end: synchroniser chain plus a consecutive-sample glitch filter.
// Back end: IDLE / WAIT_RISE / MEASURE state machine measuring rise-to-rise period and high
// time in clock cycles, flagging a static input (no rise within TIMEOUT cycles) and periods
// shorter than MIN_PERIOD. fsm_state_o exposes the state encoding for debug.
module mod_in_pwm_meas #(
   parameter int CNT_W       = 21,
   parameter int SYNC_STAGES = 2,
   parameter int GLITCH_FILT = 2,
   parameter int TIMEOUT     = 1280000,
   parameter int MIN_PERIOD  = 1280
) (
   input  logic             clk64_i,
   input  logic             rstn_i,
   mod_in_pwm_meas_if.slave bus
);

   localparam int               FC_W      = (GLITCH_FILT > 1) ? $clog2(GLITCH_FILT) : 1;
   localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(GLITCH_FILT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_RISE = 2'd1,
      ST_MEASURE   = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   flt_q;
   logic                   flt_prev_q;
   logic [FC_W-1:0]        fc_q;
   logic                   s_w;
   logic                   rise_w;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       run_q, run_d;
   logic [CNT_W-1:0]       hi_q, hi_d;
   logic [CNT_W-1:0]       per_q, per_d;
   logic [CNT_W-1:0]       duty_q, duty_d;
   logic                   valid_q, valid_d;
   logic                   upd_q, upd_d;
   logic                   stat_q, stat_d;
   logic                   ferr_q, ferr_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (x == CNT_MAX) ? x : x + ONE_C;
   endfunction

   assign s_w    = sync_q[SYNC_STAGES-1];
   assign rise_w = flt_q & ~flt_prev_q;

   // Synchroniser chain for the asynchronous pin.
   always_ff @(posedge clk64_i or negedge rstn_i) begin
      if (!rstn_i) sync_q <= '0;
      else         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.mod_in_i};
   end

   // Glitch filter: adopt the synced level after GLITCH_FILT consecutive differing samples.
   always_ff @(posedge clk64_i or negedge rstn_i) begin
      if (!rstn_i) begin
         flt_q <= 1'b0;
         fc_q  <= '0;
      end else if (s_w != flt_q) begin
         if (fc_q == FC_LAST) begin
            flt_q <= s_w;
            fc_q  <= '0;
         end else begin
            fc_q <= fc_q + FC_W'(1);
         end
      end else begin
         fc_q <= '0;
      end
   end

   // Previous filtered level for the one-cycle rise strobe.
   always_ff @(posedge clk64_i or negedge rstn_i) begin
      if (!rstn_i) flt_prev_q <= 1'b0;
      else         flt_prev_q <= flt_q;
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk64_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
         run_q   <= '0;
         hi_q    <= '0;
         per_q   <= '0;
         duty_q  <= '0;
         valid_q <= 1'b0;
         upd_q   <= 1'b0;
         stat_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         hi_q    <= hi_d;
         per_q   <= per_d;
         duty_q  <= duty_d;
         valid_q <= valid_d;
         upd_q   <= upd_d;
         stat_q  <= stat_d;
         ferr_q  <= ferr_d;
      end
   end

   // Next state, counter updates and measurement results; enable low overrides everything.
   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      hi_d    = hi_q;
      per_d   = per_q;
      duty_d  = duty_q;
      valid_d = valid_q;
      stat_d  = stat_q;
      ferr_d  = ferr_q;
      upd_d   = 1'b0;
      if (!bus.enable_i) begin
         state_d = ST_IDLE;
         run_d   = '0;
         hi_d    = '0;
         per_d   = '0;
         duty_d  = '0;
         valid_d = 1'b0;
         stat_d  = 1'b0;
         ferr_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_WAIT_RISE;
               run_d   = '0;
               hi_d    = '0;
            end
            ST_WAIT_RISE: begin
               if (rise_w) begin
                  // First rise only opens a period; nothing to report yet.
                  run_d   = ONE_C;
                  hi_d    = ONE_C;
                  state_d = ST_MEASURE;
               end else if (run_q == TIMEOUT_C) begin
                  per_d   = '0;
                  duty_d  = '0;
                  valid_d = 1'b0;
                  ferr_d  = 1'b0;
                  stat_d  = flt_q;
                  upd_d   = 1'b1;
                  run_d   = '0;
               end else begin
                  run_d = sat_inc(run_q);
               end
            end
            ST_MEASURE: begin
               if (rise_w) begin
                  // run_q / hi_q still hold the completed period and its high time.
                  upd_d = 1'b1;
                  if (run_q >= MIN_C) begin
                     per_d   = run_q;
                     duty_d  = hi_q;
                     valid_d = 1'b1;
                     ferr_d  = 1'b0;
                     stat_d  = 1'b0;
                  end else begin
                     valid_d = 1'b0;
                     ferr_d  = 1'b1;
                  end
                  run_d = ONE_C;
                  hi_d  = ONE_C;
               end else if (run_q == TIMEOUT_C) begin
                  per_d   = '0;
                  duty_d  = '0;
                  valid_d = 1'b0;
                  ferr_d  = 1'b0;
                  stat_d  = flt_q;
                  upd_d   = 1'b1;
                  run_d   = '0;
                  hi_d    = '0;
                  state_d = ST_WAIT_RISE;
               end else begin
                  run_d = sat_inc(run_q);
                  if (flt_q) hi_d = sat_inc(hi_q);
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign bus.period_count_o = per_q;
   assign bus.duty_count_o   = duty_q;
   assign bus.meas_valid_o   = valid_q;
   assign bus.update_pulse_o = upd_q;
   assign bus.static_level_o = stat_q;
   assign bus.freq_err_o     = ferr_q;
   assign bus.fsm_state_o    = state_q;

endmodule

// File: tb/tb_mod_in_pwm_meas.sv
// Bench for mod_in_pwm_meas. Time-scaled parameters keep the run short: 10 kHz / 30 % becomes
// 640 / 192 cycles, 100 kHz becomes 64 cycles, MIN_PERIOD 128, TIMEOUT 4000.
// The driver describes the pin as (high, low) periods; the reference model turns each period
// into the reports the block must make (result at the closing rise, static reports for rise-free
// stretches), queued in order. A monitor pops one entry per update_pulse_o and compares.
module tb_mod_in_pwm_meas;

   localparam int CNT_W   = 21;
   localparam int SYNC    = 2;
   localparam int GF      = 3;
   localparam int TMO     = 4000;
   localparam int MIN_P   = 128;
   localparam int EXP_W   = 2 * CNT_W + 3;
   localparam int WD_CYC  = 95000;

   logic clk;
   logic rstn;

   mod_in_pwm_meas_if #(.CNT_W(CNT_W)) bus ();

   mod_in_pwm_meas #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC),
      .GLITCH_FILT(GF),
      .TIMEOUT    (TMO),
      .MIN_PERIOD (MIN_P)
   ) dut (
      .clk64_i(clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [EXP_W-1:0] exp_q[$];
   logic [EXP_W-1:0] exp_w;
   logic [EXP_W-1:0] act_w;
   int               n_cmp;
   int               n_err;
   int               n_upd;

   // reference model state
   int m_per;
   int m_dut;
   bit m_stat;
   bit m_armed;
   int prev_p;
   int prev_h;

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_idle(input string where);
      check({where, "_period"}, 64'(bus.period_count_o), 0);
      check({where, "_duty"},   64'(bus.duty_count_o),   0);
      check({where, "_valid"},  64'(bus.meas_valid_o),   0);
      check({where, "_update"}, 64'(bus.update_pulse_o), 0);
      check({where, "_static"}, 64'(bus.static_level_o), 0);
      check({where, "_ferr"},   64'(bus.freq_err_o),     0);
   endtask

   task automatic push_exp(input int per, input int dut, input bit v, input bit f, input bit s);
      exp_q.push_back({CNT_W'(per), CNT_W'(dut), v, f, s});
   endtask

   task automatic model_clear(input string where);
      check({where, "_pending"}, 64'(exp_q.size()), 0);
      exp_q.delete();
      m_per   = 0;
      m_dut   = 0;
      m_stat  = 1'b0;
      m_armed = 1'b0;
   endtask

   // A new rise closes the previous period (if one is open) and starts a period of h high
   // and l low cycles. Any stretch of TMO cycles without a rise inside it reports "static".
   task automatic model_start_period(input int h, input int l);
      int p;
      p = h + l;
      if (m_armed) begin
         if (prev_p >= MIN_P) begin
            m_per  = prev_p;
            m_dut  = prev_h;
            m_stat = 1'b0;
            push_exp(prev_p, prev_h, 1'b1, 1'b0, 1'b0);
         end else begin
            push_exp(m_per, m_dut, 1'b0, 1'b1, m_stat);
         end
      end
      m_armed = 1'b1;
      for (int t = TMO; t < p; t += TMO + 1) begin
         m_stat  = (t < h);
         m_per   = 0;
         m_dut   = 0;
         m_armed = 1'b0;
         push_exp(0, 0, 1'b0, 1'b0, m_stat);
      end
      prev_p = p;
      prev_h = h;
   endtask

   // ---------------- driver tasks ----------------
   // g1: single-cycle low glitch position; g2: start of a (GF-1)-cycle low glitch; -1 = none.
   task automatic drive_period(input int h, input int l, input int g1, input int g2);
      model_start_period(h, l);
      for (int i = 0; i < h; i++) begin
         bus.mod_in_i = !((i == g1) || (g2 >= 0 && i >= g2 && i < g2 + GF - 1));
         step();
      end
      bus.mod_in_i = 1'b0;
      for (int i = 0; i < l; i++) step();
   endtask

   task automatic start_batch();
      bus.mod_in_i = 1'b0;
      step(20);
      bus.enable_i = 1'b1;
      step(20 + int'($urandom_range(0, 30)));
   endtask

   task automatic disable_and_check(input string where);
      bus.enable_i = 1'b0;
      step(3);
      check_idle({where, "_idle"});
      model_clear(where);
   endtask

   task automatic close_batch(input string where);
      drive_period(30, 0, -1, -1);
      disable_and_check(where);
   endtask

   task automatic rnd_period();
      int p;
      int h;
      int g1;
      int g2;
      p  = int'($urandom_range(16, 1000));
      h  = int'($urandom_range(4, p - 4));
      g1 = -1;
      g2 = -1;
      if (h >= 40 && $urandom_range(0, 1) == 1) begin
         g1 = int'($urandom_range(6, h / 2 - 4));
         g2 = int'($urandom_range(h / 2, h - 8));
      end
      drive_period(h, p - h, g1, g2);
   endtask

   // ---------------- monitor ----------------
   // Pops one expected report per update strobe.
   always @(negedge clk) begin
      if (rstn && bus.update_pulse_o) begin
         n_upd++;
         n_cmp++;
         act_w = {bus.period_count_o, bus.duty_count_o, bus.meas_valid_o,
                  bus.freq_err_o, bus.static_level_o};
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL update_%0d_unexpected: got per=%0d duty=%0d valid=%0b ferr=%0b static=%0b, expected no update",
                     n_upd, act_w[EXP_W-1 -: CNT_W], act_w[CNT_W+2:3], act_w[2], act_w[1], act_w[0]);
         end else begin
            exp_w = exp_q.pop_front();
            if (act_w !== exp_w) begin
               n_err++;
               $display("FAIL update_%0d: got per=%0d duty=%0d valid=%0b ferr=%0b static=%0b, expected per=%0d duty=%0d valid=%0b ferr=%0b static=%0b",
                        n_upd, act_w[EXP_W-1 -: CNT_W], act_w[CNT_W+2:3], act_w[2], act_w[1], act_w[0],
                        exp_w[EXP_W-1 -: CNT_W], exp_w[CNT_W+2:3], exp_w[2], exp_w[1], exp_w[0]);
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #(WD_CYC * 10);
      $display("FAIL watchdog: still running after %0d cycles, expected completion earlier", WD_CYC);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      n_cmp        = 0;
      n_err        = 0;
      n_upd        = 0;
      m_per        = 0;
      m_dut        = 0;
      m_stat       = 1'b0;
      m_armed      = 1'b0;
      prev_p       = 0;
      prev_h       = 0;
      rstn         = 1'b0;
      bus.enable_i = 1'b0;
      bus.mod_in_i = 1'b0;
      step(5);
      check_idle("reset");
      #2 rstn = 1'b1;
      step(3);

      // 10 kHz, 30 %: identical result on every completed period
      start_batch();
      repeat (5) drive_period(192, 448, -1, -1);
      close_batch("t1");

      // short low glitches inside the high phase must not alter duty or add updates
      start_batch();
      drive_period(192, 448, -1, -1);
      drive_period(192, 448, 50, 100);
      drive_period(192, 448, 30, 140);
      drive_period(192, 448, -1, -1);
      close_batch("t2");

      // static high, then toggling, then static low, then toggling again
      start_batch();
      repeat (2) drive_period(192, 448, -1, -1);
      drive_period(4500, 100, -1, -1);
      repeat (3) drive_period(192, 448, -1, -1);
      drive_period(192, 4500, -1, -1);
      repeat (3) drive_period(192, 448, -1, -1);
      close_batch("t3");

      // over-frequency after a valid result, then back to a legal period
      start_batch();
      repeat (2) drive_period(192, 448, -1, -1);
      repeat (3) drive_period(32, 32, -1, -1);
      repeat (3) drive_period(192, 448, -1, -1);
      close_batch("t4");

      // randomized periods, duties and glitches, spanning both sides of MIN_PERIOD
      start_batch();
      repeat (30) rnd_period();
      close_batch("rnd");

      // enable dropped mid high phase, then re-enabled
      start_batch();
      repeat (3) drive_period(192, 448, -1, -1);
      model_start_period(192, 448);
      bus.mod_in_i = 1'b1;
      step(60);
      disable_and_check("t5");
      start_batch();
      repeat (3) drive_period(192, 448, -1, -1);
      close_batch("t5b");

      // asynchronous reset mid high phase
      start_batch();
      repeat (3) drive_period(192, 448, -1, -1);
      model_start_period(192, 448);
      bus.mod_in_i = 1'b1;
      step(40);
      #2 rstn = 1'b0;
      #1 check_idle("t6_async");
      model_clear("t6");
      bus.mod_in_i = 1'b0;
      step(3);
      rstn = 1'b1;
      step(2);
      start_batch();
      repeat (4) drive_period(192, 448, -1, -1);
      close_batch("t6b");

      step(50);
      check("queue_empty_at_end", 64'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
